dlbf_data_axis2ram_64b: RTL

DLBF_DATA_AXIS2RAM_64B -- requirements
Module: dlbf_data_axis2ram_64b

---
 rtl/dlbf_data_axis2ram_64b.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/dlbf_data_axis2ram_64b.sv
// AXI4-Stream to RAM capture engine: writes accepted beats to sequential RAM
// addresses, tracks blocks/iterations, flags tlast (and optionally tkeep) errors.
// Optional feature: define DLBF_CAPTURE_TKEEP_CHECK_EN to enable the partial-tkeep check.
module dlbf_data_axis2ram_64b #(
  parameter int DATA_WIDTH = 64,
  parameter int RAM_DEPTH  = 4096
) (
  input  logic                    s_axis_clk,
  input  logic                    s_axis_rst,
  input  logic                    go,
  input  logic [11:0]             block_size,
  input  logic [11:0]             niter,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  output logic                    s_axis_tready,
  output logic                    ram_we,
  output logic [15:0]             ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_din,
  output logic                    done,
  output logic                    tlast_err,
  output logic                    tkeep_err
);

  localparam logic [15:0] PTR_LAST = 16'(RAM_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE} state_t;

  logic [1:0]            rst_sync_q;
  logic                  rst_i;
  state_t                state_q, state_d;
  logic                  go_q, go_d;
  logic [15:0]           ptr_q, ptr_d;
  logic [11:0]           blk_q, blk_d;
  logic [11:0]           iter_q, iter_d;
  logic                  tlast_err_q, tlast_err_d;
  logic                  tkeep_err_q, tkeep_err_d;
  logic                  ram_we_q, ram_we_d;
  logic [15:0]           ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_din_q, ram_din_d;
  logic                  accept;
  logic                  blk_last;
  logic [11:0]           bs_m1;
  logic [11:0]           niter_m1;

  // Reset asserts immediately but releases only after two clean clock edges.
  always_ff @(posedge s_axis_clk or posedge s_axis_rst) begin
    if (s_axis_rst) rst_sync_q <= 2'b11;
    else            rst_sync_q <= {rst_sync_q[0], 1'b0};
  end
  assign rst_i = rst_sync_q[1];

  // block_size=0 wraps to 4095 here, giving a 4096-beat block for free.
  assign bs_m1    = block_size - 12'd1;
  assign niter_m1 = niter - 12'd1;
  assign blk_last = (blk_q == bs_m1);

  // Gating with go_q makes an abort drop tready one cycle after go falls.
  assign s_axis_tready = (state_q == S_CAPTURE) && go_q;
  assign accept        = s_axis_tvalid && s_axis_tready;

`ifndef DLBF_CAPTURE_TKEEP_CHECK_EN
  logic unused_tkeep;
  assign unused_tkeep = ^s_axis_tkeep;
`endif

  always_comb begin
    state_d     = state_q;
    go_d        = go;
    ptr_d       = ptr_q;
    blk_d       = blk_q;
    iter_d      = iter_q;
    tlast_err_d = tlast_err_q;
    tkeep_err_d = tkeep_err_q;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;

    if (accept) begin
      ram_we_d   = 1'b1;
      ram_addr_d = ptr_q;
      ram_din_d  = s_axis_tdata;
    end

    case (state_q)
      S_IDLE: begin
        if (go_q) begin
          state_d     = S_CAPTURE;
          ptr_d       = '0;
          blk_d       = '0;
          iter_d      = '0;
          tlast_err_d = 1'b0;
          tkeep_err_d = 1'b0;
        end
      end
      S_CAPTURE: begin
        if (!go_q) begin
          state_d = S_IDLE;
          ptr_d   = '0;
          blk_d   = '0;
          iter_d  = '0;
        end else if (accept) begin
          ptr_d = (ptr_q == PTR_LAST) ? 16'd0 : ptr_q + 16'd1;
          if (s_axis_tlast != blk_last) tlast_err_d = 1'b1;
`ifdef DLBF_CAPTURE_TKEEP_CHECK_EN
          if (s_axis_tkeep != '1) tkeep_err_d = 1'b1;
`endif
          if (blk_last) begin
            blk_d  = '0;
            iter_d = iter_q + 12'd1;
            if ((niter != 12'd0) && (iter_q == niter_m1)) state_d = S_DONE;
          end else begin
            blk_d = blk_q + 12'd1;
          end
        end
      end
      S_DONE: begin
        if (!go_q) begin
          state_d = S_IDLE;
          ptr_d   = '0;
          blk_d   = '0;
          iter_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge s_axis_clk or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      go_q        <= 1'b0;
      ptr_q       <= '0;
      blk_q       <= '0;
      iter_q      <= '0;
      tlast_err_q <= 1'b0;
      tkeep_err_q <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
    end else begin
      state_q     <= state_d;
      go_q        <= go_d;
      ptr_q       <= ptr_d;
      blk_q       <= blk_d;
      iter_q      <= iter_d;
      tlast_err_q <= tlast_err_d;
      tkeep_err_q <= tkeep_err_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
    end
  end

  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;
  assign done      = (state_q == S_DONE);
  assign tlast_err = tlast_err_q;
  assign tkeep_err = tkeep_err_q;

endmodule
